// File: rtl/imm_extend_queue.sv
// imm_extend_queue: immediate extender feeding a DEPTH-entry FIFO.
// Each immediate is extended (sign / zero / upper / sign-magnitude,
// with an optional left shift by 2) as it is presented, and the 32-bit
// result is buffered so decode can run ahead of the execute stage.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. in_ready depends only on the registered
// occupancy (and rst_n), never on out_ready, so a pop in the same cycle
// as a full queue does not open a slot until the following cycle.
// out_valid/out_data come straight from storage, so an item pushed at
// edge N appears after edge N, and the head holds steady while stalled.
module imm_extend_queue #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_imm,
  input  logic [1:0]           in_mode,
  input  logic                 in_shl2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0] count
);

  localparam int E     = OUT_WIDTH - IN_WIDTH;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);
  localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(DEPTH - 1);

  logic [OUT_WIDTH-1:0] ext_raw;
  logic [OUT_WIDTH-1:0] ext_res;

  logic [OUT_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic push;
  logic pop;

  // Extend the incoming immediate according to its mode, then optionally
  // scale it to a word offset (bits shifted past the MSB are dropped).
  always_comb begin
    ext_raw = '0;
    case (in_mode)
      2'b00:   ext_raw = {{E{in_imm[IN_WIDTH-1]}}, in_imm};
      2'b01:   ext_raw = {{E{1'b0}}, in_imm};
      2'b10:   ext_raw = {in_imm, {E{1'b0}}};
      default: ext_raw = {in_imm[IN_WIDTH-1], {E{1'b0}}, in_imm[IN_WIDTH-2:0]};
    endcase
    ext_res = in_shl2 ? (ext_raw << 2) : ext_raw;
  end

  assign in_ready  = rst_n && (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Next pointer and occupancy values; pointers wrap at DEPTH-1 so any
  // DEPTH works, not only powers of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Queue state; reset clears storage too so the head reads 0, not X.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= ext_res;
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_queue.sv
// Bench for imm_extend_queue at default parameters (16/32/4).
module tb_imm_extend_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        in_shl2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  mode;
    logic        shl2;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  imm_extend_queue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .in_shl2   (in_shl2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference extension from the arithmetic meaning of each mode.
  function automatic logic [31:0] ref_ext(input logic [15:0] imm,
                                          input logic [1:0] m,
                                          input logic s);
    longint u;
    longint r;
    u = longint'(imm);
    case (m)
      2'd0:    r = (u >= 32768) ? u - 65536 : u;
      2'd1:    r = u;
      2'd2:    r = u * 65536;
      default: r = (u >= 32768) ? 64'h8000_0000 + (u - 32768) : u;
    endcase
    if (s) r = r * 4;
    r = r & 64'hFFFF_FFFF;
    return r[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, check outputs against the model,
  // then advance the model by what the edge should do.
  task automatic cycle(input logic v, input logic [15:0] imm, input logic [1:0] m,
                       input logic s, input logic ordy, input logic rst_released);
    int sz;
    logic do_push;
    logic do_pop;
    in_valid  = v;
    in_imm    = imm;
    in_mode   = m;
    in_shl2   = s;
    out_ready = ordy;
    rst_n     = rst_released;
    #1;
    sz = exp_q.size();
    chk("in_ready", {31'd0, in_ready}, {31'd0, (rst_released && sz != DEPTH)});
    chk("out_valid", {31'd0, out_valid}, {31'd0, (sz != 0)});
    chk("count", {29'd0, count}, sz);
    if (sz != 0) chk("out_data", out_data, exp_q[0]);
    do_push = v && rst_released && (sz != DEPTH);
    do_pop  = ordy && (sz != 0);
    @(posedge clk);
    if (!rst_released) begin
      exp_q.delete();
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(ref_ext(imm, m, s));
    end
    #1;
  endtask

  task automatic push_item(input logic [15:0] imm, input logic [1:0] m, input logic s);
    cycle(1'b1, imm, m, s, 1'b0, 1'b1);
  endtask

  task automatic pop_item();
    cycle(1'b0, 16'h0, 2'd0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    vecs[0]  = '{16'h8005, 2'd0, 1'b0, 32'hFFFF8005};
    vecs[1]  = '{16'h8005, 2'd1, 1'b0, 32'h00008005};
    vecs[2]  = '{16'h8005, 2'd2, 1'b0, 32'h80050000};
    vecs[3]  = '{16'h8005, 2'd3, 1'b0, 32'h80000005};
    vecs[4]  = '{16'hFFFF, 2'd0, 1'b1, 32'hFFFFFFFC};
    vecs[5]  = '{16'h4000, 2'd2, 1'b1, 32'h00000000};
    vecs[6]  = '{16'h7FFF, 2'd0, 1'b0, 32'h00007FFF};
    vecs[7]  = '{16'h8000, 2'd3, 1'b0, 32'h80000000};
    vecs[8]  = '{16'hFFFF, 2'd3, 1'b1, 32'h0001FFFC};
    vecs[9]  = '{16'h0001, 2'd1, 1'b1, 32'h00000004};
    vecs[10] = '{16'h1234, 2'd2, 1'b0, 32'h12340000};
    vecs[11] = '{16'h2001, 2'd0, 1'b1, 32'h00008004};

    // Reset held 2 cycles with in_valid=1: nothing may be queued.
    in_valid = 1'b1; in_imm = 16'h1111; in_mode = 2'd0; in_shl2 = 1'b0;
    out_ready = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    cycle(1'b1, 16'h1111, 2'd0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h2222, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    rst_n = 1'b1; in_valid = 1'b0; #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Table vectors in groups of DEPTH: fill to full, then drain in order.
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < DEPTH; k++) begin
        push_item(vecs[g*DEPTH+k].imm, vecs[g*DEPTH+k].mode, vecs[g*DEPTH+k].shl2);
      end
      chk("full_count", {29'd0, count}, 32'd4);
      chk("full_in_ready", {31'd0, in_ready}, 32'd0);
      for (int k = 0; k < DEPTH; k++) begin
        chk("vec_data", out_data, vecs[g*DEPTH+k].exp);
        pop_item();
      end
    end

    // Full: 5th item held off; a pop while full frees the slot a cycle later.
    for (int k = 0; k < 5; k++) cycle(1'b1, 16'h0100 + 16'(k), 2'd1, 1'b0, 1'b0, 1'b1);
    chk("hold5_count", {29'd0, count}, 32'd4);
    cycle(1'b1, 16'h0104, 2'd1, 1'b0, 1'b1, 1'b1);
    chk("pop_full_count", {29'd0, count}, 32'd3);
    cycle(1'b1, 16'h0104, 2'd1, 1'b0, 1'b0, 1'b1);
    chk("accept5_count", {29'd0, count}, 32'd4);
    for (int k = 0; k < DEPTH; k++) begin
      chk("order_data", out_data, 32'h00000101 + 32'(k));
      pop_item();
    end

    // Streaming: push and pop every cycle, occupancy pinned at 1.
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, 16'h0200 + 16'(k), 2'd1, 1'b0, 1'b1, 1'b1);
      chk("stream_count", {29'd0, count}, 32'd1);
      chk("stream_data", out_data, 32'h00000200 + 32'(k));
    end
    pop_item();

    // Reset mid-stream at count=3, then a fresh push.
    for (int k = 0; k < 3; k++) push_item(16'h0300 + 16'(k), 2'd0, 1'b0);
    chk("pre_rst_count", {29'd0, count}, 32'd3);
    cycle(1'b0, 16'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_count", {29'd0, count}, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    push_item(16'h0001, 2'd1, 1'b0);
    chk("post_rst_data", out_data, 32'h00000001);
    pop_item();

    // Randomized traffic against the queue model, with rare resets.
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 99) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
